// File: rtl/aes_pkg.sv
// aes_pkg: AES byte substitution tables, GF(2^8) helpers, round constants and core state encoding
package aes_pkg;
  localparam int NR_AES128 = 10;
  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_e;
  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p;
    p = x;
    for (int i = 0; i < 6; i++) p = gmul(gmul(p, p), x);
    return gmul(p, p);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction
endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one AES inverse round, InvMixColumns skipped when last
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [0:127] st,
  input  logic [0:127] rk,
  input  logic         last,
  output logic [0:127] next_st
);
  logic [0:127] a, m;

  function automatic logic [7:0] mix_coef(input int j);
    return j == 0 ? 8'h0e : j == 1 ? 8'h0b : j == 2 ? 8'h0d : 8'h09;
  endfunction

  always_comb begin
    a = '0;
    m = '0;
    for (int i = 0; i < 16; i++)
      a[8*i +: 8] = inv_sbox(st[8*(i%4 + 4*((i/4 - i%4) & 3)) +: 8]) ^ rk[8*i +: 8];
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 4; k++)
        m[8*i +: 8] = m[8*i +: 8] ^ gmul(mix_coef((k - i%4) & 3), a[8*(4*(i/4) + k) +: 8]);
    next_st = last ? a : m;
  end
endmodule

// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: iterative AES-128 decryptor; define AES_DEC_DBG_EN for dbg_round/dbg_state/dbg_proto_err
module aes_decrypt_core
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [0:127] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [0:127] ct_in,
  input  logic         ct_valid,
  output logic         ct_ready,
  output logic [0:127] pt_out,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic         key_loaded
`ifdef AES_DEC_DBG_EN
  ,
  output logic [3:0]   dbg_round,
  output logic [2:0]   dbg_state,
  output logic         dbg_proto_err
`endif
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic key_loaded_q, key_loaded_d, pt_valid_q, pt_valid_d;
  logic [0:127] pt_out_q, pt_out_d, st_q, st_d, nxt, prev, kx;
  logic [0:10][0:127] rk_q, rk_d;
  logic [0:31] w3, t;

  if (NR != NR_AES128) begin : g_nr_check
    $error("aes_decrypt_core supports only NR=10");
  end

  aes_inv_round u_round (.st(st_q), .rk(rk_q[cnt_q]), .last(cnt_q == 4'd0), .next_st(nxt));

  assign key_ready = state_q == IDLE;
  assign ct_ready = key_ready & key_loaded_q & ~key_valid;
  assign key_loaded = key_loaded_q;
  assign pt_valid = pt_valid_q;
  assign pt_out = pt_out_q;

  // next round key: RotWord/SubWord/Rcon on the last word, then the XOR chain
  always_comb begin
    prev = rk_q[cnt_q - 4'd1];
    w3 = prev[96:127];
    t = {sbox(w3[8:15]) ^ RCON[cnt_q], sbox(w3[16:23]), sbox(w3[24:31]), sbox(w3[0:7])};
    kx[0:31] = prev[0:31] ^ t;
    kx[32:63] = prev[32:63] ^ kx[0:31];
    kx[64:95] = prev[64:95] ^ kx[32:63];
    kx[96:127] = w3 ^ kx[64:95];
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    key_loaded_d = key_loaded_q;
    pt_valid_d = pt_valid_q;
    pt_out_d = pt_out_q;
    st_d = st_q;
    rk_d = rk_q;
    case (state_q)
      IDLE:
        if (key_valid) begin
          rk_d[0] = key_in;
          key_loaded_d = 1'b0;
          cnt_d = 4'd1;
          state_d = KEYEXP;
        end else if (ct_valid & ct_ready) begin
          st_d = ct_in ^ rk_q[NR];
          cnt_d = 4'(NR - 1);
          state_d = ROUND;
        end
      KEYEXP: begin
        rk_d[cnt_q] = kx;
        cnt_d = cnt_q + 4'd1;
        key_loaded_d = cnt_q == 4'(NR);
        state_d = cnt_q == 4'(NR) ? IDLE : KEYEXP;
      end
      ROUND: begin
        st_d = nxt;
        cnt_d = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
        pt_out_d = cnt_q == 4'd0 ? nxt : pt_out_q;
        pt_valid_d = cnt_q == 4'd0;
        state_d = cnt_q == 4'd0 ? DONE : ROUND;
      end
      DONE: begin
        pt_valid_d = ~pt_ready;
        state_d = pt_ready ? IDLE : DONE;
      end
    endcase
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      key_loaded_q <= 1'b0;
      pt_valid_q <= 1'b0;
      pt_out_q <= '0;
      st_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      key_loaded_q <= key_loaded_d;
      pt_valid_q <= pt_valid_d;
      pt_out_q <= pt_out_d;
      st_q <= st_d;
    end

  always_ff @(posedge clk) rk_q <= rk_d;

`ifdef AES_DEC_DBG_EN
  logic ct_pend_q, ct_pend_d, key_pend_q, key_pend_d, err_q, err_d;

  always_comb begin
    ct_pend_d = ct_valid & ~ct_ready;
    key_pend_d = key_valid & ~key_ready;
    err_d = err_q | (ct_pend_q & ~ct_valid) | (key_pend_q & ~key_valid);
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      ct_pend_q <= 1'b0;
      key_pend_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ct_pend_q <= ct_pend_d;
      key_pend_q <= key_pend_d;
      err_q <= err_d;
    end

  assign dbg_round = cnt_q;
  assign dbg_state = {1'b0, state_q};
  assign dbg_proto_err = err_q;
`endif
endmodule
